// File: rtl/fft_cbfp_pkg.sv
// +----------------------------------------------------------------------------+
// | fft_cbfp_pkg : shared types, modes and sign-bit counting for the CBFP block |
// | Revision     : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

package fft_cbfp_pkg;

    localparam int DIN_W_DEF     = 25;
    localparam int DOUT_W_DEF    = 12;
    localparam int LANES_DEF     = 16;
    localparam int BLK_BEATS_DEF = 4;

    localparam logic MODE_BEAT = 1'b0;
    localparam logic MODE_BLK  = 1'b1;

    typedef logic signed [DIN_W_DEF-1:0]  sample_in_t;
    typedef logic signed [DOUT_W_DEF-1:0] sample_out_t;

    // Redundant sign bits of the w-bit value held in x[w-1:0]; upper bits ignored.
    function automatic int lsc(input logic [63:0] x, input int w);
        int   n;
        logic run;
        n   = 0;
        run = 1'b1;
        for (int i = 62; i >= 0; i--) begin
            if ((i < w - 1) && run) begin
                if (x[i] == x[w-1]) n++;
                else                run = 1'b0;
            end
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fft_cbfp_if.sv
// +----------------------------------------------------------------------------+
// | fft_cbfp_if : beat-level input and output bus of the CBFP normaliser        |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

interface fft_cbfp_if
    import fft_cbfp_pkg::*;
#(
    parameter int DIN_W  = DIN_W_DEF,
    parameter int DOUT_W = DOUT_W_DEF,
    parameter int LANES  = LANES_DEF,
    parameter int IDX_W  = $clog2(DIN_W)
);
    logic                         val_in;
    logic                         mode_blk;
    logic [LANES-1:0][DIN_W-1:0]  re_in;
    logic [LANES-1:0][DIN_W-1:0]  im_in;
    logic                         val_out;
    logic                         last_out;
    logic [LANES-1:0][DOUT_W-1:0] re_out;
    logic [LANES-1:0][DOUT_W-1:0] im_out;
    logic [IDX_W-1:0]             index_out;

    modport master (
        output val_in, mode_blk, re_in, im_in,
        input  val_out, last_out, re_out, im_out, index_out
    );

    modport slave (
        input  val_in, mode_blk, re_in, im_in,
        output val_out, last_out, re_out, im_out, index_out
    );
endinterface

`default_nettype wire

// File: rtl/fft_cbfp_lsc_min.sv
// +----------------------------------------------------------------------------+
// | fft_cbfp_lsc_min : minimum redundant-sign count over all re/im of one beat  |
// | Revision         : 1.0                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module fft_cbfp_lsc_min
    import fft_cbfp_pkg::*;
#(
    parameter int DIN_W = DIN_W_DEF,
    parameter int LANES = LANES_DEF,
    parameter int IDX_W = $clog2(DIN_W)
) (
    input  logic [LANES-1:0][DIN_W-1:0] i_re,
    input  logic [LANES-1:0][DIN_W-1:0] i_im,
    output logic [IDX_W-1:0]            o_min_lsc
);
    always_comb begin
        o_min_lsc = IDX_W'(DIN_W - 1);
        for (int l = 0; l < LANES; l++) begin
            if (IDX_W'(lsc(64'(i_re[l]), DIN_W)) < o_min_lsc)
                o_min_lsc = IDX_W'(lsc(64'(i_re[l]), DIN_W));
            if (IDX_W'(lsc(64'(i_im[l]), DIN_W)) < o_min_lsc)
                o_min_lsc = IDX_W'(lsc(64'(i_im[l]), DIN_W));
        end
    end
endmodule

`default_nettype wire

// File: rtl/fft_cbfp_block.sv
// +----------------------------------------------------------------------------+
// | fft_cbfp_block : ping-pong block-floating-point normaliser for FFT output   |
// | Revision       : 1.0                                                        |
// +----------------------------------------------------------------------------+
`default_nettype none

module fft_cbfp_block
    import fft_cbfp_pkg::*;
#(
    parameter int DIN_W     = DIN_W_DEF,
    parameter int DOUT_W    = DOUT_W_DEF,
    parameter int LANES     = LANES_DEF,
    parameter int BLK_BEATS = BLK_BEATS_DEF,
    parameter int IDX_W     = $clog2(DIN_W)
) (
    input  logic      clk,
    input  logic      rst,
    fft_cbfp_if.slave bus
);
    localparam int               CNT_W      = (BLK_BEATS > 1) ? $clog2(BLK_BEATS) : 1;
    localparam logic [IDX_W-1:0] c_MIN_INIT = IDX_W'(DIN_W - 1);
    localparam logic [0:0]       c_RD_IDLE  = 1'b0;
    localparam logic [0:0]       c_RD_DRAIN = 1'b1;

    typedef logic [LANES-1:0][DIN_W-1:0]  beat_in_t;
    typedef logic [LANES-1:0][DOUT_W-1:0] beat_out_t;

    beat_in_t r_mem_re [2][BLK_BEATS];
    beat_in_t r_mem_im [2][BLK_BEATS];

    logic [CNT_W-1:0] r_wcnt, r_hand_last, r_rcnt, r_rlast, w_last_cnt;
    logic [IDX_W-1:0] r_wmin, r_hand_min, r_shift, w_beat_min, w_run_min;
    logic             r_wb, r_rb, r_wmode, r_pend, w_mode, w_wr_last;
    logic [0:0]       r_state, w_state_nx;
    logic             w_take, w_rd_last;

    logic             r_val_out, r_last_out;
    beat_out_t        r_re_out, r_im_out, w_sh_re, w_sh_im;
    logic [IDX_W-1:0] r_index_out;

    fft_cbfp_lsc_min #(
        .DIN_W (DIN_W),
        .LANES (LANES),
        .IDX_W (IDX_W)
    ) u_lsc_min (
        .i_re      (bus.re_in),
        .i_im      (bus.im_in),
        .o_min_lsc (w_beat_min)
    );

    // Mode is taken live on a block's first beat, then held until handoff.
    always_comb begin
        w_mode     = (r_wcnt == '0) ? bus.mode_blk : r_wmode;
        w_last_cnt = (w_mode == MODE_BLK) ? CNT_W'(BLK_BEATS - 1) : '0;
        w_wr_last  = bus.val_in && (r_wcnt == w_last_cnt);
        w_run_min  = (w_beat_min < r_wmin) ? w_beat_min : r_wmin;
    end

    always_ff @(posedge clk) begin
        if (bus.val_in) begin
            r_mem_re[r_wb][r_wcnt] <= bus.re_in;
            r_mem_im[r_wb][r_wcnt] <= bus.im_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wcnt      <= '0;
            r_wb        <= 1'b0;
            r_wmode     <= MODE_BLK;
            r_wmin      <= c_MIN_INIT;
            r_hand_min  <= '0;
            r_hand_last <= '0;
            r_pend      <= 1'b0;
        end else begin
            if (bus.val_in) begin
                r_wmode <= w_mode;
                if (w_wr_last) begin
                    r_wcnt      <= '0;
                    r_wb        <= ~r_wb;
                    r_wmin      <= c_MIN_INIT;
                    r_hand_min  <= w_run_min;
                    r_hand_last <= w_last_cnt;
                end else begin
                    r_wcnt <= r_wcnt + 1'b1;
                    r_wmin <= w_run_min;
                end
            end
            // A new handoff on the same edge as a take re-arms the flag.
            r_pend <= w_wr_last | (r_pend & ~w_take);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_RD_IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_take     = 1'b0;
        w_rd_last  = 1'b0;
        case (r_state)
            c_RD_IDLE: begin
                if (r_pend) begin
                    w_state_nx = c_RD_DRAIN;
                    w_take     = 1'b1;
                end
            end
            c_RD_DRAIN: begin
                if (r_rcnt == r_rlast) begin
                    w_rd_last  = 1'b1;
                    w_take     = r_pend;
                    w_state_nx = r_pend ? c_RD_DRAIN : c_RD_IDLE;
                end
            end
            default: w_state_nx = c_RD_IDLE;
        endcase
    end

    // Left shift keeps the top DOUT_W bits; the chosen shift never drops a sign bit.
    for (genvar l = 0; l < LANES; l++) begin : g_shift
        assign w_sh_re[l] = DOUT_W'((r_mem_re[r_rb][r_rcnt][l] << r_shift) >> (DIN_W - DOUT_W));
        assign w_sh_im[l] = DOUT_W'((r_mem_im[r_rb][r_rcnt][l] << r_shift) >> (DIN_W - DOUT_W));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rcnt      <= '0;
            r_rlast     <= '0;
            r_rb        <= 1'b0;
            r_shift     <= '0;
            r_val_out   <= 1'b0;
            r_last_out  <= 1'b0;
            r_re_out    <= '0;
            r_im_out    <= '0;
            r_index_out <= '0;
        end else begin
            if (w_take) begin
                r_shift <= r_hand_min;
                r_rlast <= r_hand_last;
            end
            if (r_state == c_RD_DRAIN) begin
                r_rcnt      <= w_rd_last ? '0 : r_rcnt + 1'b1;
                r_rb        <= w_rd_last ? ~r_rb : r_rb;
                r_val_out   <= 1'b1;
                r_last_out  <= w_rd_last;
                r_re_out    <= w_sh_re;
                r_im_out    <= w_sh_im;
                r_index_out <= r_shift;
            end else begin
                r_val_out   <= 1'b0;
                r_last_out  <= 1'b0;
                r_re_out    <= '0;
                r_im_out    <= '0;
                r_index_out <= '0;
            end
        end
    end

    assign bus.val_out   = r_val_out;
    assign bus.last_out  = r_last_out;
    assign bus.re_out    = r_re_out;
    assign bus.im_out    = r_im_out;
    assign bus.index_out = r_index_out;
endmodule

`default_nettype wire

// File: tb/tb_fft_cbfp_block.sv
// +----------------------------------------------------------------------------+
// | tb_fft_cbfp_block : directed self-checking bench for fft_cbfp_block         |
// | Revision          : 1.0                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_fft_cbfp_block;
    import fft_cbfp_pkg::*;

    localparam int DIN_W = 25, DOUT_W = 12, LANES = 16, BLK_BEATS = 4, IDX_W = 5;

    typedef logic [LANES-1:0][DIN_W-1:0]  vin_t;
    typedef logic [LANES-1:0][DOUT_W-1:0] vout_t;
    typedef struct {
        vout_t            re;
        vout_t            im;
        logic [IDX_W-1:0] idx;
        logic             last;
        int               cyc;
    } obs_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    cyc = 0;
    int    total = 0;
    int    bad = 0;
    int    sent_cyc = 0;
    obs_t  q[$];
    vout_t zero_out = '0;

    fft_cbfp_if #(.DIN_W(DIN_W), .DOUT_W(DOUT_W), .LANES(LANES), .IDX_W(IDX_W)) bus ();

    fft_cbfp_block #(
        .DIN_W(DIN_W), .DOUT_W(DOUT_W), .LANES(LANES), .BLK_BEATS(BLK_BEATS), .IDX_W(IDX_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial forever #5 clk = ~clk;

    // Output monitor: stamps each valid beat with the rising-edge count that produced it.
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        #1;
        if (bus.val_out === 1'b1)
            q.push_back('{bus.re_out, bus.im_out, bus.index_out, bus.last_out, cyc});
    end

    function automatic vin_t fill_in(input logic [DIN_W-1:0] v);
        vin_t r;
        for (int l = 0; l < LANES; l++) r[l] = v;
        return r;
    endfunction

    function automatic vout_t fill_out(input logic [DOUT_W-1:0] v);
        vout_t r;
        for (int l = 0; l < LANES; l++) r[l] = v;
        return r;
    endfunction

    task automatic send(input logic mode, input vin_t re, input vin_t im);
        @(negedge clk);
        bus.val_in   = 1'b1;
        bus.mode_blk = mode;
        bus.re_in    = re;
        bus.im_in    = im;
        sent_cyc     = cyc + 1;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.val_in = 1'b0;
            bus.re_in  = '0;
            bus.im_in  = '0;
        end
    endtask

    task automatic wait_beats(input int n, input string tag);
        int t = 0;
        while (q.size() < n && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (6) @(negedge clk);
        total++;
        if (q.size() != n) begin
            $display("FAIL %s_count got=%0d want=%0d", tag, q.size(), n);
            bad++;
        end
    endtask

    task automatic test_reset();
        bus.val_in = 1'b0; bus.mode_blk = 1'b1; bus.re_in = '0; bus.im_in = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            total++; if (bus.val_out !== 1'b0)   begin $display("FAIL rst_val got=%b want=0", bus.val_out); bad++; end
            total++; if (bus.last_out !== 1'b0)  begin $display("FAIL rst_last got=%b want=0", bus.last_out); bad++; end
            total++; if (bus.index_out !== '0)   begin $display("FAIL rst_idx got=%0d want=0", bus.index_out); bad++; end
            total++; if (bus.re_out !== zero_out) begin $display("FAIL rst_re got=%h want=0", bus.re_out); bad++; end
            total++; if (bus.im_out !== zero_out) begin $display("FAIL rst_im got=%h want=0", bus.im_out); bad++; end
            rst = 1'b0;
            repeat (3) @(negedge clk);
        end
    endtask

    // Mode is only sampled on the first beat, so beats 1..3 carry mode_blk=0.
    task automatic test_block_ones();
        vout_t e_re = fill_out(12'd1024);
        q.delete();
        for (int b = 0; b < 4; b++) send((b == 0), fill_in(25'd1), '0);
        gap(1);
        wait_beats(4, "t1");
        for (int b = 0; b < 4 && b < q.size(); b++) begin
            total++; if (q[b].re !== e_re)      begin $display("FAIL t1_re b%0d got=%h want=%h", b, q[b].re, e_re); bad++; end
            total++; if (q[b].im !== zero_out)  begin $display("FAIL t1_im b%0d got=%h want=0", b, q[b].im); bad++; end
            total++; if (q[b].idx !== 5'd23)    begin $display("FAIL t1_idx b%0d got=%0d want=23", b, q[b].idx); bad++; end
            total++; if (q[b].last !== (b == 3)) begin $display("FAIL t1_last b%0d got=%b want=%b", b, q[b].last, b == 3); bad++; end
        end
        if (q.size() == 4) begin
            total++;
            if (q[3].cyc - q[0].cyc != 3) begin $display("FAIL t1_gapless got=%0d want=3", q[3].cyc - q[0].cyc); bad++; end
        end
    endtask

    task automatic test_block_negmax();
        vin_t  in2 = fill_in(25'd1000);
        vout_t e2  = '0;
        in2[5]   = 25'h1000000;
        e2[5]    = 12'h800;
        q.delete();
        for (int b = 0; b < 4; b++) send(1'b1, (b == 2) ? in2 : fill_in(25'd1000), fill_in(25'd1000));
        gap(1);
        wait_beats(4, "t2");
        for (int b = 0; b < 4 && b < q.size(); b++) begin
            total++;
            if (q[b].re !== ((b == 2) ? e2 : zero_out)) begin
                $display("FAIL t2_re b%0d got=%h want=%h", b, q[b].re, (b == 2) ? e2 : zero_out); bad++;
            end
            total++; if (q[b].im !== zero_out) begin $display("FAIL t2_im b%0d got=%h want=0", b, q[b].im); bad++; end
            total++; if (q[b].idx !== 5'd0)    begin $display("FAIL t2_idx b%0d got=%0d want=0", b, q[b].idx); bad++; end
        end
    endtask

    task automatic test_per_beat();
        vin_t  a = fill_in(25'h400);
        vin_t  c = fill_in(25'h10000);
        vout_t ea = fill_out(12'd512);
        vout_t ec = fill_out(12'd128);
        a[0] = 25'h000FFF; ea[0] = 12'd2047;
        c[0] = 25'h0FFFFF; ec[0] = 12'd2047;
        q.delete();
        send(1'b0, a, '0);
        send(1'b0, c, '0);
        gap(1);
        wait_beats(2, "t3");
        if (q.size() == 2) begin
            total++; if (q[0].re !== ea)     begin $display("FAIL t3_re0 got=%h want=%h", q[0].re, ea); bad++; end
            total++; if (q[0].idx !== 5'd12) begin $display("FAIL t3_idx0 got=%0d want=12", q[0].idx); bad++; end
            total++; if (q[1].re !== ec)     begin $display("FAIL t3_re1 got=%h want=%h", q[1].re, ec); bad++; end
            total++; if (q[1].idx !== 5'd4)  begin $display("FAIL t3_idx1 got=%0d want=4", q[1].idx); bad++; end
            total++; if ({q[0].last, q[1].last} !== 2'b11) begin $display("FAIL t3_last got=%b%b want=11", q[0].last, q[1].last); bad++; end
            total++; if (q[1].cyc - q[0].cyc != 1) begin $display("FAIL t3_gapless got=%0d want=1", q[1].cyc - q[0].cyc); bad++; end
        end
    endtask

    task automatic test_back_to_back();
        int c3 = 0;
        q.delete();
        for (int b = 0; b < 12; b++) begin
            send(1'b1, fill_in(25'd1), '0);
            if (b == 3) c3 = sent_cyc;
        end
        gap(1);
        wait_beats(12, "t4");
        if (q.size() == 12) begin
            total++; if (q[0].cyc != c3 + 2)        begin $display("FAIL t4_latency got=%0d want=%0d", q[0].cyc, c3 + 2); bad++; end
            total++; if (q[11].cyc - q[0].cyc != 11) begin $display("FAIL t4_gapless got=%0d want=11", q[11].cyc - q[0].cyc); bad++; end
            for (int b = 0; b < 12; b++) begin
                total++;
                if (q[b].last !== (b % 4 == 3) || q[b].idx !== 5'd23 || q[b].re[7] !== 12'd1024) begin
                    $display("FAIL t4_beat b%0d got=last%b idx%0d re%0d want=last%b idx23 re1024", b, q[b].last, q[b].idx, q[b].re[7], b % 4 == 3);
                    bad++;
                end
            end
        end
    endtask

    task automatic test_reset_mid_block();
        vout_t e_re = fill_out(12'd1024);
        q.delete();
        send(1'b1, fill_in(25'h0ABCDE), '0);
        send(1'b1, fill_in(25'h0ABCDE), '0);
        @(negedge clk);
        bus.val_in = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        total++; if (bus.val_out !== 1'b0) begin $display("FAIL t5_rst_val got=%b want=0", bus.val_out); bad++; end
        rst = 1'b0;
        for (int b = 0; b < 4; b++) send(1'b1, fill_in(25'd1), '0);
        gap(1);
        wait_beats(4, "t5");
        for (int b = 0; b < 4 && b < q.size(); b++) begin
            total++;
            if (q[b].re !== e_re || q[b].idx !== 5'd23 || q[b].last !== (b == 3)) begin
                $display("FAIL t5_beat b%0d got=re%h idx%0d last%b want=re%h idx23 last%b", b, q[b].re, q[b].idx, q[b].last, e_re, b == 3);
                bad++;
            end
        end
    endtask

    task automatic test_zero_gaps();
        for (int g = 0; g < 2; g++) begin
            q.delete();
            for (int b = 0; b < 4; b++) begin
                send(1'b1, '0, '0);
                if (g == 1) gap(3);
            end
            gap(1);
            wait_beats(4, "t6");
            for (int b = 0; b < 4 && b < q.size(); b++) begin
                total++;
                if (q[b].re !== zero_out || q[b].im !== zero_out || q[b].idx !== 5'd24 || q[b].last !== (b == 3)) begin
                    $display("FAIL t6_beat g%0d b%0d got=idx%0d last%b want=idx24 last%b zero", g, b, q[b].idx, q[b].last, b == 3);
                    bad++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_block_ones();
        test_block_negmax();
        test_per_beat();
        test_back_to_back();
        test_reset_mid_block();
        test_zero_gaps();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
